// File: rtl/support_stage_controller.sv
// Round sequencer for the decoder: drives the shared stage bus through
// load -> (grow -> merge -> write-back)* -> result, ending on all-grown or iteration limit.
module support_stage_controller #(
  parameter int NUM_LINKS    = 16,
  parameter int STAGE_WIDTH  = 3,
  parameter int MERGE_CYCLES = 4,
  parameter int WB_CYCLES    = 3,
  parameter int MAX_ITER     = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            load_done,
  input  logic [NUM_LINKS-1:0]            fully_grown_in,
  input  logic                            result_ack,
  output logic [STAGE_WIDTH-1:0]          global_stage,
  output logic                            result_valid,
  output logic                            timeout,
  output logic [$clog2(MAX_ITER+1)-1:0]   iter_count,
  output logic                            busy
);

  localparam int IW   = $clog2(MAX_ITER + 1);
  localparam int CMAX = (MERGE_CYCLES > WB_CYCLES) ? MERGE_CYCLES : WB_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = STAGE_WIDTH'(3);
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM        = STAGE_WIDTH'(4);
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = STAGE_WIDTH'(5);

  localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_GROW   = 3'd2,
    S_MERGE  = 3'd3,
    S_WB     = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cyc_q, cyc_d;
  logic [IW-1:0]            iter_q, iter_d;
  logic                     timeout_q, timeout_d;
  logic [STAGE_WIDTH-1:0]   stage_q, stage_d;
  logic                     result_valid_q, busy_q;
  logic                     all_grown_s;

  assign all_grown_s = &fully_grown_in;

  // Next-state, phase counter and round bookkeeping.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          iter_d    = '0;
          timeout_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (load_done) state_d = S_GROW;
        else           state_d = S_LOAD;
      end
      S_GROW: begin
        state_d = S_MERGE;
        cyc_d   = CW'(MERGE_CYCLES - 1);
      end
      S_MERGE: begin
        if (cyc_q == '0) begin
          state_d = S_WB;
          cyc_d   = CW'(WB_CYCLES - 1);
          if (iter_q != ITER_MAX) iter_d = iter_q + IW'(1);
          else                    iter_d = iter_q;
        end else begin
          cyc_d = cyc_q - CW'(1);
        end
      end
      S_WB: begin
        // Flags are only trusted in the final cycle; earlier ones predate this iteration.
        if (cyc_q != '0) begin
          cyc_d = cyc_q - CW'(1);
        end else if (all_grown_s) begin
          state_d   = S_RESULT;
          timeout_d = 1'b0;
        end else if (iter_q == ITER_MAX) begin
          state_d   = S_RESULT;
          timeout_d = 1'b1;
        end else begin
          state_d = S_GROW;
        end
      end
      S_RESULT: begin
        if (result_ack) state_d = S_IDLE;
        else            state_d = S_RESULT;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  // Stage bus encoding of the upcoming state.
  always_comb begin
    case (state_d)
      S_IDLE:   stage_d = STAGE_IDLE;
      S_LOAD:   stage_d = STAGE_MEASUREMENT_LOADING;
      S_GROW:   stage_d = STAGE_GROW;
      S_MERGE:  stage_d = STAGE_MERGE;
      S_WB:     stage_d = STAGE_WRITE_TO_MEM;
      S_RESULT: stage_d = STAGE_RESULT_VALID;
      default:  stage_d = STAGE_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cyc_q          <= '0;
      iter_q         <= '0;
      timeout_q      <= 1'b0;
      stage_q        <= STAGE_IDLE;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      iter_q         <= iter_d;
      timeout_q      <= timeout_d;
      stage_q        <= stage_d;
      result_valid_q <= (state_d == S_RESULT);
      busy_q         <= (state_d != S_IDLE);
    end
  end

  assign global_stage = stage_q;
  assign result_valid = result_valid_q;
  assign timeout      = timeout_q;
  assign iter_count   = iter_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_support_stage_controller.sv
// Randomized round-level bench: expected stage traces are built per round from
// load delay, grow iteration and ack delay, then compared cycle by cycle.
module tb_support_stage_controller;

  localparam int NL = 16;
  localparam int SW = 3;
  localparam int MC = 4;
  localparam int WC = 3;
  localparam int MI = 15;
  localparam int IW = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_GROW   = 3'd2;
  localparam logic [2:0] ST_MERGE  = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_RESULT = 3'd5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          load_done = 1'b0;
  logic [NL-1:0] fully_grown_in = '0;
  logic          result_ack = 1'b0;
  logic [SW-1:0] global_stage;
  logic          result_valid;
  logic          timeout;
  logic [IW-1:0] iter_count;
  logic          busy;

  int errors = 0;
  int checks = 0;

  support_stage_controller #(
    .NUM_LINKS(NL), .STAGE_WIDTH(SW), .MERGE_CYCLES(MC), .WB_CYCLES(WC), .MAX_ITER(MI)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .load_done(load_done),
    .fully_grown_in(fully_grown_in), .result_ack(result_ack),
    .global_stage(global_stage), .result_valid(result_valid), .timeout(timeout),
    .iter_count(iter_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stage"}, 32'(global_stage), 32'(ST_IDLE));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rvalid"}, 32'(result_valid), 32'd0);
  endtask

  function automatic logic [NL-1:0] not_all_ones();
    logic [NL-1:0] v;
    v = NL'($urandom);
    v[$urandom_range(0, NL-1)] = 1'b0;
    return v;
  endfunction

  // One round: idle gap, start, L extra LOAD cycles, links all grown from iteration G
  // onward (G > MI means never), ack raised after A RESULT cycles.
  task automatic run_round(input int gap, input int L, input int G, input int A);
    logic [2:0] q[$];
    int wbp[$];
    int itn[$];
    int n_exp;
    int rstart;
    logic [2:0] nxt;
    n_exp = (G > MI) ? MI : G;

    start = 1'b0;
    for (int i = 0; i < gap; i++) begin
      load_done = 1'($urandom_range(0, 1));
      result_ack = 1'($urandom_range(0, 1));
      fully_grown_in = NL'($urandom);
      tick();
      check_idle_outputs("gap");
    end
    start = 1'b1;
    tick();
    check("start_stage", 32'(global_stage), 32'(ST_LOAD));
    check("start_busy", 32'(busy), 32'd1);
    check("start_iter", 32'(iter_count), 32'd0);
    check("start_timeout", 32'(timeout), 32'd0);

    for (int i = 0; i <= L; i++) begin q.push_back(ST_LOAD); wbp.push_back(0); itn.push_back(0); end
    for (int it = 1; it <= n_exp; it++) begin
      q.push_back(ST_GROW); wbp.push_back(0); itn.push_back(it);
      for (int m = 0; m < MC; m++) begin q.push_back(ST_MERGE); wbp.push_back(0); itn.push_back(it); end
      for (int w = 1; w <= WC; w++) begin q.push_back(ST_WB); wbp.push_back(w); itn.push_back(it); end
    end
    rstart = q.size();
    for (int i = 0; i <= A; i++) begin q.push_back(ST_RESULT); wbp.push_back(0); itn.push_back(0); end
    q.push_back(ST_IDLE); wbp.push_back(0); itn.push_back(0);

    for (int k = 0; k < q.size() - 1; k++) begin
      start = 1'($urandom_range(0, 1));
      load_done = (q[k] == ST_LOAD) ? (k == L) : 1'($urandom_range(0, 1));
      result_ack = (q[k] == ST_RESULT) ? (k == rstart + A) : 1'($urandom_range(0, 1));
      if (wbp[k] == WC)
        fully_grown_in = (itn[k] >= G) ? {NL{1'b1}} : not_all_ones();
      else
        fully_grown_in = ($urandom_range(0, 1) == 1) ? {NL{1'b1}} : NL'($urandom);
      tick();
      nxt = q[k+1];
      check("stage", 32'(global_stage), 32'(nxt));
      check("rvalid", 32'(result_valid), 32'(nxt == ST_RESULT));
      check("busy", 32'(busy), 32'(nxt != ST_IDLE));
      if (nxt == ST_RESULT || nxt == ST_IDLE) begin
        check("iter", 32'(iter_count), 32'(n_exp));
        check("timeout", 32'(timeout), 32'(G > MI));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #12;
    check_idle_outputs("in_reset");
    check("in_reset_iter", 32'(iter_count), 32'd0);
    check("in_reset_timeout", 32'(timeout), 32'd0);
    #10;
    reset = 1'b1;
    tick();
    check_idle_outputs("post_reset");

    // Async reset mid-MERGE of the second iteration.
    start = 1'b1;
    tick();
    check("rst_load", 32'(global_stage), 32'(ST_LOAD));
    start = 1'b0;
    load_done = 1'b1;
    tick();
    check("rst_grow", 32'(global_stage), 32'(ST_GROW));
    load_done = 1'b0;
    fully_grown_in = '0;
    repeat (9) tick();
    check("rst_merge", 32'(global_stage), 32'(ST_MERGE));
    check("rst_merge_iter", 32'(iter_count), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_iter", 32'(iter_count), 32'd0);
    check("async_rst_timeout", 32'(timeout), 32'd0);
    tick();
    check_idle_outputs("held_rst");
    #2;
    reset = 1'b1;

    run_round(1, 2, 1, 0);     // grown in iteration 1
    run_round(0, 0, 3, 2);     // three iterations, back-to-back start
    run_round(2, 1, 99, 4);    // one link never grows: timeout
    run_round(0, 3, 15, 0);    // grows exactly at the last allowed iteration
    run_round(1, 0, 16, 1);    // one past the limit: timeout
    for (int r = 0; r < 10; r++)
      run_round($urandom_range(0, 2), $urandom_range(0, 4),
                $urandom_range(1, 18), $urandom_range(0, 5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/support_stage_controller.md
# support_stage_controller

Sequences `global_stage` for the support-neighbor links and the decoding fabric. Runs one decode round as load → repeated grow/merge/write-back iterations → result. After each iteration it reduces the links' `fully_grown` flags and either ends the round or starts another grow. It sits at the top of the decoder and drives the shared stage bus that every link and node registers.

## Interface
- `NUM_LINKS`, default 16: number of `fully_grown` flags reduced.
- `STAGE_WIDTH`, default 3: width of the stage bus (shared constant).
- `MERGE_CYCLES`, default 4: cycles spent in STAGE_MERGE per iteration (≥1).
- `WB_CYCLES`, default 3: cycles spent in STAGE_WRITE_TO_MEM per iteration (≥3, covers the 2-register flag path).
- `MAX_ITER`, default 15: grow iterations allowed before timeout (≥1).
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin a round; sampled only in IDLE.
- `load_done` in 1: measurement loading complete; sampled only in LOAD.
- `fully_grown_in` in NUM_LINKS: per-link grown flags.
- `result_ack` in 1: consumer accepted the result; sampled only in RESULT.
- `global_stage` out STAGE_WIDTH: registered stage bus.
- `result_valid` out 1: high throughout RESULT.
- `timeout` out 1: round ended by MAX_ITER; valid while `result_valid`.
- `iter_count` out $clog2(MAX_ITER+1): completed grow iterations of current/last round.
- `busy` out 1: high in every state except IDLE.

## Operation
- States map to stage constants as follows:
  - IDLE → STAGE_IDLE
  - LOAD → STAGE_MEASUREMENT_LOADING
  - GROW → STAGE_GROW
  - MERGE → STAGE_MERGE
  - WB → STAGE_WRITE_TO_MEM
  - RESULT → STAGE_RESULT_VALID
- `global_stage` is a register equal to the encoding of the current state.
- IDLE:
  - `start`=1 → LOAD.
  - Clear `iter_count` and `timeout` on this transition.
- LOAD: `load_done`=1 → GROW. Wait indefinitely otherwise.
- GROW: exactly 1 cycle, then → MERGE.
- MERGE:
  - Lasts MERGE_CYCLES cycles, tracked by down-counter `cyc_cnt`, then → WB.
  - `iter_count` increments (saturating at MAX_ITER) on the MERGE→WB transition.
- WB:
  - Lasts WB_CYCLES cycles.
  - `fully_grown_in` is evaluated only in the last WB cycle. Earlier values are ignored because they are stale.
  - All flags set → RESULT with `timeout`=0.
  - Otherwise, if `iter_count`==MAX_ITER → RESULT with `timeout`=1.
  - Otherwise → GROW.
- RESULT:
  - `result_valid`=1.
  - `result_ack`=1 → IDLE.
  - `iter_count` and `timeout` hold until the next `start`.
- Flag reduction is the AND of all NUM_LINKS bits. NUM_LINKS=1 degenerates to the single bit.
- `start` outside IDLE, `load_done` outside LOAD and `result_ack` outside RESULT are ignored. None of them are queued.
- Reset asserted in any state, mid-round included:
  - `global_stage` = STAGE_IDLE, state = IDLE, `cyc_cnt` = 0, `iter_count` = 0.
  - `timeout` = 0, `result_valid` = 0, `busy` = 0.
  - Takes effect immediately (asynchronous); the first transition is on the first edge after deassertion.

## Timing
- All outputs are registered; no combinational input→output paths.
- `start` sampled high at edge k → `global_stage`=MEASUREMENT_LOADING after edge k.
- `load_done` at edge k → GROW after edge k, MERGE after edge k+1.
- MERGE is visible for exactly MERGE_CYCLES cycles; WB for exactly WB_CYCLES cycles.
- Per-iteration period = 1 + MERGE_CYCLES + WB_CYCLES cycles (8 at defaults).
- Link path: a link registers the stage at edge +1 and updates `fully_grown` at edge +2 after WB first appears. The WB_CYCLES≥3 bound guarantees the evaluated sample reflects the current iteration.
- `result_valid` rises on the edge that leaves WB. It falls on the edge that samples `result_ack`; `result_ack` high at that edge → IDLE next cycle.
- `start` held high continuously gives back-to-back rounds with one IDLE cycle between them.

## Test plan
- Reset mid-MERGE, `reset`=0 asynchronously between edges → `global_stage`=STAGE_IDLE before the next edge; all outputs at reset values; `start` after release runs normally.
- Defaults; `start`, `load_done` 2 cycles later; links report all grown in iteration 1 → exactly 1 GROW, 4 MERGE and 3 WB cycles, then RESULT with `iter_count`=1, `timeout`=0.
- Link model grows after 3 iterations → stage trace repeats GROW/MERGE×4/WB×3 three times; `iter_count`=3, `timeout`=0; total 24 cycles from first GROW to RESULT.
- One link never grows, MAX_ITER=15 → RESULT after 15 iterations, `timeout`=1, `iter_count`=15; no 16th GROW.
- Stale-flag check: `fully_grown_in`=all-ones only in the first two WB cycles, zero in the third → controller loops to GROW, not RESULT.
- Spurious inputs: `start` during GROW/MERGE, `result_ack` during LOAD, `load_done` during WB → no effect on state or stage trace. `result_ack` held 5 cycles after RESULT entry → `result_valid` high exactly until the ack edge, then IDLE.
